// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-0 (CPOL=0, CPHA=0) byte master.
// Converts a valid/ready byte stream into SPI frames (MSB first) and returns the
// byte captured on MISO during each transmitted byte as a one-cycle rx_valid pulse.
// A frame is a run of bytes ended by the one flagged tx_last; NSS stays low between
// bytes of a frame for as long as the source keeps it waiting.
//
// Ports:
//   clk, reset_n          system clock (rising edge), asynchronous active-low reset
//   tx_data/valid/last    byte source; accepted when tx_valid && tx_ready
//   tx_ready              high in IDLE and GAP only
//   rx_data/rx_valid      received byte, one-cycle pulse, no backpressure
//   busy                  high whenever the master is not idle
//   SPI_NSS/SCLK/MOSI     serial outputs, all registered
//   SPI_MISO              serial input, sampled on the SCLK rising transition
module spi_byte_master #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned NSS_SETUP = 2,
   parameter int unsigned NSS_HOLD  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       SPI_NSS,
   output logic       SPI_SCLK,
   output logic       SPI_MOSI,
   input  logic       SPI_MISO
);

   // One shared phase counter covers the SCLK half-period, NSS setup and NSS hold.
   localparam int unsigned CNT_MAX_A = (CLK_DIV > NSS_SETUP) ? CLK_DIV : NSS_SETUP;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > NSS_HOLD) ? CNT_MAX_A : NSS_HOLD;
   localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(NSS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(NSS_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_GAP   = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       tx_sh_q, tx_sh_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic             last_q, last_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;
   logic             nss_q, nss_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             accept_c;

   // tx_ready_q is only ever high in IDLE/GAP, so this is the byte handshake.
   assign accept_c = tx_valid && tx_ready_q;

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      last_d     = last_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      nss_d      = nss_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[7];
               nss_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            if (cnt_q == SETUP_END) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_SHIFT: begin
            if (cnt_q == DIV_END) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  // Rising transition: capture MISO.
                  sclk_d  = 1'b1;
                  rx_sh_d = {rx_sh_q[6:0], SPI_MISO};
               end else begin
                  // Falling transition: advance MOSI or close the byte.
                  sclk_d = 1'b0;
                  if (bit_q == 3'd7) begin
                     rx_data_d  = rx_sh_q;
                     rx_valid_d = 1'b1;
                     state_d    = last_q ? S_HOLD : S_GAP;
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     tx_sh_d = {tx_sh_q[6:0], 1'b0};
                     mosi_d  = tx_sh_q[6];
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_GAP: begin
            // Mid-frame: next byte goes straight to SHIFT, NSS already asserted.
            if (accept_c) begin
               tx_sh_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[7];
               cnt_d   = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end
         end

         S_HOLD: begin
            // Two phases split by nss_q: NSS low for the hold time, then high for it.
            if (cnt_q == HOLD_END) begin
               cnt_d = '0;
               if (!nss_q) begin
                  nss_d = 1'b1;
               end else begin
                  mosi_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            nss_d   = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase

      // Status outputs are a function of the next state only.
      tx_ready_d = (state_d == S_IDLE) || (state_d == S_GAP);
      busy_d     = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         last_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         nss_q      <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         last_q     <= last_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         nss_q      <= nss_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;
   assign SPI_NSS  = nss_q;
   assign SPI_SCLK = sclk_q;
   assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: table vectors, hand sequences (timing, mid-frame reset,
// fast divider) and random frames for spi_byte_master. A bench-side SPI slave
// records MOSI bytes and serves MISO bytes; expected received bytes are either the
// transmitted bytes (loopback) or the slave's bytes.
module tb_spi_byte_master;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned NSS_SETUP  = 2;
   localparam int unsigned NSS_HOLD   = 2;
   localparam int unsigned CLK_DIV6   = 1;
   localparam int unsigned NSS_SETUP6 = 1;
   localparam int unsigned NSS_HOLD6  = 2;

   typedef struct {
      int         n;
      bit         lpbk;
      int         gap;
      logic [7:0] tx[4];
      logic [7:0] sl[4];
      logic [7:0] exp_rx[4];
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   always #5 clk = ~clk;

   // main DUT
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0, tx_last = 1'b0;
   logic       tx_ready, rx_valid, busy, spi_nss, spi_sclk, spi_mosi, spi_miso;
   logic [7:0] rx_data;
   logic       lpbk_mode = 1'b1;
   logic       sl_miso = 1'b0;
   assign spi_miso = lpbk_mode ? spi_mosi : sl_miso;

   spi_byte_master #(.CLK_DIV(CLK_DIV), .NSS_SETUP(NSS_SETUP), .NSS_HOLD(NSS_HOLD)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .SPI_NSS(spi_nss), .SPI_SCLK(spi_sclk), .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso)
   );

   // fast-divider DUT, always looped back
   logic [7:0] tx6_data = 8'h00;
   logic       tx6_valid = 1'b0, tx6_last = 1'b0;
   logic       tx6_ready, rx6_valid, busy6, nss6, sclk6, mosi6;
   logic [7:0] rx6_data;

   spi_byte_master #(.CLK_DIV(CLK_DIV6), .NSS_SETUP(NSS_SETUP6), .NSS_HOLD(NSS_HOLD6)) u_dut6 (
      .clk(clk), .reset_n(reset_n),
      .tx_data(tx6_data), .tx_valid(tx6_valid), .tx_last(tx6_last), .tx_ready(tx6_ready),
      .rx_data(rx6_data), .rx_valid(rx6_valid), .busy(busy6),
      .SPI_NSS(nss6), .SPI_SCLK(sclk6), .SPI_MOSI(mosi6), .SPI_MISO(mosi6)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout, expected DUT event", name);
   endtask

   // ---------------- monitor + slave model for the main DUT ----------------
   int         cyc = 0, proto_err = 0, rise_cnt = 0, nss_rises = 0, hi_run = 0;
   int         sl_bits = 0, mosi_hi = 0, gap_err = 0;
   int         t_fall = 0, t_rise1 = 0, t_rise2 = 0, t_lastfall = 0;
   int         t_nssrise = 0, t_busyfall = 0, t_rxv = 0;
   logic       p_nss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_rxv = 1'b0, p_busy = 1'b0;
   logic [7:0] mosi_acc = 8'h00;
   logic [7:0] sl_bytes[4];
   logic [7:0] rx_seen[$];
   logic [7:0] mosi_seen[$];

   function automatic logic sl_bit(input int k);
      logic [7:0] b;
      if (k >= 32) return 1'b0;
      b = sl_bytes[k / 8];
      return b[7 - (k % 8)];
   endfunction

   task automatic proto_fail(input string name);
      proto_err++;
      if (proto_err <= 10) $display("FAIL protocol %s at cycle %0d: got violation, expected none", name, cyc);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (p_nss && !spi_nss) begin
         t_fall   = cyc;
         rise_cnt = 0;
         sl_bits  = 0;
         sl_miso  = sl_bit(0);
      end
      if (!p_nss && spi_nss) begin
         t_nssrise = cyc;
         nss_rises++;
      end
      if (!p_sclk && spi_sclk) begin
         rise_cnt++;
         hi_run = 0;
         if (rise_cnt == 1) t_rise1 = cyc;
         if (rise_cnt == 2) t_rise2 = cyc;
         mosi_acc = {mosi_acc[6:0], spi_mosi};
         sl_bits++;
         if (sl_bits % 8 == 0) mosi_seen.push_back(mosi_acc);
         if (p_mosi != spi_mosi) proto_fail("mosi_changed_on_rise");
      end
      if (p_sclk && !spi_sclk) begin
         t_lastfall = cyc;
         sl_miso    = sl_bit(sl_bits);
         if (reset_n && hi_run != int'(CLK_DIV)) proto_fail("sclk_high_width");
      end
      if (p_sclk && spi_sclk && p_mosi != spi_mosi) proto_fail("mosi_changed_while_high");
      if (spi_sclk) hi_run++;
      if (spi_nss && spi_sclk) proto_fail("sclk_high_without_nss");
      if (!spi_nss && spi_mosi) mosi_hi++;
      if (rx_valid) begin
         rx_seen.push_back(rx_data);
         t_rxv = cyc;
         if (p_rxv) proto_fail("rx_valid_wider_than_one");
      end
      if (p_busy && !busy) t_busyfall = cyc;
      p_nss  = spi_nss;
      p_sclk = spi_sclk;
      p_mosi = spi_mosi;
      p_rxv  = rx_valid;
      p_busy = busy;
   end

   // ---------------- monitor for the fast DUT ----------------
   int         cyc6 = 0, r6_cnt = 0, t6_fall = 0, t6_rise1 = 0, t6_lastfall = 0;
   logic       p6_nss = 1'b1, p6_sclk = 1'b0;
   logic [7:0] rx6_seen[$];

   always @(negedge clk) begin
      cyc6++;
      if (p6_nss && !nss6) begin
         t6_fall = cyc6;
         r6_cnt  = 0;
      end
      if (!p6_sclk && sclk6) begin
         r6_cnt++;
         if (r6_cnt == 1) t6_rise1 = cyc6;
      end
      if (p6_sclk && !sclk6) t6_lastfall = cyc6;
      if (rx6_valid) rx6_seen.push_back(rx6_data);
      p6_nss  = nss6;
      p6_sclk = sclk6;
   end

   // ---------------- stimulus helpers ----------------
   function automatic vec_t mk_vec(input int n, input bit lpbk, input int gap,
                                   input logic [31:0] txw, input logic [31:0] slw,
                                   input logic [31:0] expw);
      vec_t v;
      v.n    = n;
      v.lpbk = lpbk;
      v.gap  = gap;
      for (int i = 0; i < 4; i++) begin
         v.tx[i]     = txw[31 - 8*i -: 8];
         v.sl[i]     = slw[31 - 8*i -: 8];
         v.exp_rx[i] = expw[31 - 8*i -: 8];
      end
      return v;
   endfunction

   // gap==0: next byte presented right after the previous accept (held while busy);
   // gap>0 : wait until the master idles mid-frame, then stay idle gap cycles.
   task automatic send_bytes(input logic [7:0] b[4], input int n, input int gap);
      int t;
      for (int i = 0; i < n; i++) begin
         if (i > 0 && gap > 0) begin
            t = 0;
            while (!tx_ready && t < 400) begin @(negedge clk); t++; end
            if (!tx_ready) timeout("gap_entry");
            for (int g = 0; g < gap; g++) begin
               tx_last = 1'b1;
               if (!(spi_nss == 1'b0 && spi_sclk == 1'b0 && tx_ready && busy)) gap_err++;
               @(negedge clk);
            end
         end
         tx_data  = b[i];
         tx_last  = (i == n - 1);
         tx_valid = 1'b1;
         t = 0;
         while (!tx_ready && t < 400) begin @(negedge clk); t++; end
         if (!tx_ready) timeout("accept");
         @(negedge clk);
         tx_valid = 1'b0;
         tx_last  = 1'b0;
         tx_data  = 8'($urandom);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t;
      lpbk_mode = v.lpbk;
      sl_bytes  = v.sl;
      rx_seen.delete();
      mosi_seen.delete();
      nss_rises = 0;
      gap_err   = 0;
      mosi_hi   = 0;
      send_bytes(v.tx, v.n, v.gap);
      t = 0;
      while (busy && t < 600) begin @(negedge clk); t++; end
      if (busy) timeout({tag, ".frame_end"});
      #1;
      chk({tag, ".rx_count"}, rx_seen.size(), v.n);
      chk({tag, ".nss_rises"}, nss_rises, 1);
      for (int i = 0; i < v.n; i++) begin
         if (i < rx_seen.size()) chk($sformatf("%s.rx%0d", tag, i), rx_seen[i], v.exp_rx[i]);
         if (i < mosi_seen.size()) chk($sformatf("%s.mosi%0d", tag, i), mosi_seen[i], v.tx[i]);
      end
      if (v.gap > 0) chk({tag, ".gap_hold"}, gap_err, 0);
   endtask

   vec_t vt[6];

   initial begin
      int t;
      vec_t rv;
      logic [31:0] txw, slw;
      bit lp;
      int n;

      for (int i = 0; i < 4; i++) sl_bytes[i] = 8'h00;
      //                n  lpbk gap  tx            slave         expected rx
      vt[0] = mk_vec(1, 1'b1, 0,  32'hA5000000, 32'h00000000, 32'hA5000000);
      vt[1] = mk_vec(3, 1'b1, 0,  32'h0180FF00, 32'h00000000, 32'h0180FF00);
      vt[2] = mk_vec(1, 1'b0, 0,  32'h00000000, 32'h3C000000, 32'h3C000000);
      vt[3] = mk_vec(2, 1'b1, 20, 32'h55AA0000, 32'h00000000, 32'h55AA0000);
      vt[4] = mk_vec(1, 1'b1, 0,  32'h0F000000, 32'h00000000, 32'h0F000000);
      vt[5] = mk_vec(2, 1'b0, 3,  32'hFF000000, 32'h817E0000, 32'h817E0000);

      // reset values
      #22;
      chk("rst.nss", spi_nss, 1'b1);
      chk("rst.sclk", spi_sclk, 1'b0);
      chk("rst.mosi", spi_mosi, 1'b0);
      chk("rst.rx_valid", rx_valid, 1'b0);
      chk("rst.rx_data", rx_data, 8'h00);
      chk("rst.busy", busy, 1'b0);
      chk("rst.tx_ready", tx_ready, 1'b1);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // single byte loopback with frame timing
      run_vec(vt[0], "t1");
      chk("t1.setup_to_first_rise", t_rise1 - t_fall, NSS_SETUP + CLK_DIV);
      chk("t1.sclk_period", t_rise2 - t_rise1, 2 * CLK_DIV);
      chk("t1.frame_to_last_fall", t_lastfall - t_fall, NSS_SETUP + 16 * CLK_DIV);
      chk("t1.rx_valid_time", t_rxv - t_fall, NSS_SETUP + 16 * CLK_DIV);
      chk("t1.nss_hold", t_nssrise - t_lastfall, NSS_HOLD);
      chk("t1.nss_high_min", t_busyfall - t_nssrise, NSS_HOLD);

      run_vec(vt[1], "t2");
      run_vec(vt[2], "t3");
      chk("t3.mosi_high_cycles", mosi_hi, 0);
      run_vec(vt[3], "t4");
      run_vec(vt[5], "tab5");

      // reset after the third SCLK rise of 0xF0
      lpbk_mode = 1'b1;
      rx_seen.delete();
      @(negedge clk);
      tx_data = 8'hF0; tx_last = 1'b1; tx_valid = 1'b1;
      @(negedge clk);
      #1;
      tx_valid = 1'b0; tx_last = 1'b0;
      t = 0;
      while (rise_cnt < 3 && t < 400) begin @(negedge clk); #1; t++; end
      if (rise_cnt < 3) timeout("t5.third_rise");
      chk("t5.pre_reset_busy", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("t5.nss", spi_nss, 1'b1);
      chk("t5.sclk", spi_sclk, 1'b0);
      chk("t5.mosi", spi_mosi, 1'b0);
      chk("t5.busy", busy, 1'b0);
      chk("t5.tx_ready", tx_ready, 1'b1);
      chk("t5.rx_data", rx_data, 8'h00);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (80) @(negedge clk);
      #1;
      chk("t5.no_rx_valid", rx_seen.size(), 0);
      chk("t5.idle_after", busy, 1'b0);
      run_vec(vt[4], "t5b");

      // fast divider on the second instance
      rx6_seen.delete();
      @(negedge clk);
      tx6_data = 8'hC3; tx6_last = 1'b1; tx6_valid = 1'b1;
      t = 0;
      while (!tx6_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
      tx6_valid = 1'b0; tx6_last = 1'b0;
      t = 0;
      while (busy6 && t < 200) begin @(negedge clk); t++; end
      if (busy6) timeout("t6.frame_end");
      #1;
      chk("t6.rx_count", rx6_seen.size(), 1);
      if (rx6_seen.size() > 0) chk("t6.rx", rx6_seen[0], 8'hC3);
      chk("t6.setup_to_first_rise", t6_rise1 - t6_fall, NSS_SETUP6 + CLK_DIV6);
      chk("t6.frame_to_last_fall", t6_lastfall - t6_fall, NSS_SETUP6 + 16 * CLK_DIV6);

      // random frames: rx equals tx in loopback, else the slave's bytes
      for (int k = 0; k < 40; k++) begin
         n   = int'($urandom_range(1, 4));
         lp  = 1'($urandom_range(0, 1));
         txw = $urandom;
         slw = $urandom;
         rv  = mk_vec(n, lp, int'($urandom_range(0, 3)), txw, slw, lp ? txw : slw);
         run_vec(rv, $sformatf("rnd%0d", k));
      end

      chk("protocol_violations", proto_err, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
